memory_bus_arbiter: RTL and testbench

MEMORY_BUS_ARBITER -- requirements
Module: memory_bus_arbiter

---
 rtl/memory_bus_arbiter_pkg.sv | 35 +++
 rtl/memory_bus_arbiter_tag.sv | 57 +++++
 rtl/memory_bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_memory_bus_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: source identifiers, bus packet
// layout and the arbiter state encoding.
package memory_bus_arbiter_pkg;

  localparam int DATA_W        = 64;
  localparam int ADDR_W        = 64;
  localparam int CORE_ID_W     = 4;
  localparam int WITHIN_CORE_W = 4;
  localparam int SRC_W         = CORE_ID_W + WITHIN_CORE_W;

  typedef logic [CORE_ID_W-1:0] core_id_t;

  typedef struct packed {
    core_id_t                 core_id;
    logic [WITHIN_CORE_W-1:0] within_core_id;
  } source_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    source_t           source;
  } bus_packet_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // Index width that stays at least one bit wide for tiny requester counts.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/memory_bus_arbiter_tag.sv
// Synchronous tag FIFO holding {requester index, source} for every read in
// flight, so responses can be routed back in issue order.
module arb_tag_fifo
  import memory_bus_arbiter_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 10,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage array: written on push only, never reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap freely.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (do_push && !do_pop)      count_reg <= count_reg + CNT_W'(1);
      else if (do_pop && !do_push) count_reg <= count_reg - CNT_W'(1);
    end
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter placing one requester at a time on the memory bus and
// routing read responses back through an in-order tag FIFO.
module memory_bus_arbiter
  import memory_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_write,
  input  logic [NUM_REQ*64-1:0]    req_addr,
  input  logic [NUM_REQ*64-1:0]    req_data,
  input  logic [NUM_REQ*SRC_W-1:0] req_source,
  output logic [NUM_REQ-1:0]       req_accept,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [63:0]              resp_data,
  output logic                     mem_req_valid,
  output logic                     mem_req_write,
  output logic [63:0]              mem_req_addr,
  output logic [63:0]              mem_req_data,
  output logic [SRC_W-1:0]         mem_req_source,
  input  logic                     mem_req_ready,
  input  logic                     mem_resp_valid,
  input  logic [63:0]              mem_resp_data,
  input  logic [SRC_W-1:0]         mem_resp_source,
  output logic                     error
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int TAG_W = IDX_W + SRC_W;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef logic [IDX_W-1:0] idx_t;

  arb_state_t          state_reg, state_next;
  idx_t                grant_idx_reg, rr_ptr_reg, win_idx, head_idx;
  bus_packet_t         pkt_reg;
  logic                error_reg, win_found, transfer;
  logic [NUM_REQ-1:0]  resp_valid_reg, eligible;
  logic [63:0]         resp_data_reg;
  logic [DATA_W-1:0]   addr_arr [NUM_REQ];
  logic [DATA_W-1:0]   data_arr [NUM_REQ];
  source_t             src_arr  [NUM_REQ];
  logic [TAG_W-1:0]    tag_head;
  logic [SRC_W-1:0]    head_src;
  logic [CNT_W-1:0]    tag_count;
  logic                tag_full, tag_empty, tag_push, tag_pop;
  logic                grant_drop, resp_orphan, resp_mismatch;
  int                  cand;

  // Unpack per-requester payloads; a read is only eligible while a tag slot is free.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign addr_arr[gi]   = req_addr[gi*DATA_W +: DATA_W];
    assign data_arr[gi]   = req_data[gi*DATA_W +: DATA_W];
    assign src_arr[gi]    = req_source[gi*SRC_W +: SRC_W];
    assign eligible[gi]   = req_valid[gi] && (req_write[gi] || !tag_full);
    assign req_accept[gi] = transfer && (grant_idx_reg == idx_t'(gi));
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(rr_ptr_reg) + off) % NUM_REQ;
      if (!win_found && eligible[idx_t'(cand)]) begin
        win_found = 1'b1;
        win_idx   = idx_t'(cand);
      end
    end
  end

  // Next-state: pick a winner in IDLE, hold the locked grant until the bus takes it.
  always_comb begin
    state_next = state_reg;
    transfer   = 1'b0;
    case (state_reg)
      ST_IDLE:  if (win_found) state_next = ST_GRANT;
      ST_GRANT: if (mem_req_ready) begin
        transfer   = 1'b1;
        state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Latch the winner and its payload; advance the round-robin pointer on transfer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      grant_idx_reg <= '0;
      rr_ptr_reg    <= idx_t'(NUM_REQ - 1);
      pkt_reg       <= '0;
    end else begin
      if (state_reg == ST_IDLE && win_found) begin
        grant_idx_reg  <= win_idx;
        pkt_reg.write  <= req_write[win_idx];
        pkt_reg.addr   <= addr_arr[win_idx];
        pkt_reg.data   <= data_arr[win_idx];
        pkt_reg.source <= src_arr[win_idx];
      end
      if (transfer) rr_ptr_reg <= grant_idx_reg;
    end
  end

  assign mem_req_valid  = (state_reg == ST_GRANT);
  assign mem_req_write  = pkt_reg.write;
  assign mem_req_addr   = pkt_reg.addr;
  assign mem_req_data   = pkt_reg.data;
  assign mem_req_source = pkt_reg.source;

  assign tag_push = transfer && !pkt_reg.write;
  assign tag_pop  = mem_resp_valid && (tag_count != '0);
  assign head_idx = tag_head[SRC_W +: IDX_W];
  assign head_src = tag_head[SRC_W-1:0];

  arb_tag_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(TAG_W)) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tag_push),
    .push_data ({grant_idx_reg, pkt_reg.source}),
    .pop       (tag_pop),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  // Route a popped response to its requester one cycle later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      resp_valid_reg <= '0;
      resp_data_reg  <= '0;
    end else begin
      resp_valid_reg <= '0;
      if (tag_pop) begin
        resp_valid_reg[head_idx] <= 1'b1;
        resp_data_reg            <= mem_resp_data;
      end
    end
  end

  assign resp_valid = resp_valid_reg;
  assign resp_data  = resp_data_reg;

  assign grant_drop    = (state_reg == ST_GRANT) && !req_valid[grant_idx_reg];
  assign resp_orphan   = mem_resp_valid && tag_empty;
  assign resp_mismatch = mem_resp_valid && !tag_empty && (mem_resp_source != head_src);

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset)                                          error_reg <= 1'b0;
    else if (grant_drop || resp_orphan || resp_mismatch) error_reg <= 1'b1;
  end

  assign error = error_reg;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized run against a
// transaction-level reference model.
module tb_memory_bus_arbiter;
  import memory_bus_arbiter_pkg::*;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid, req_write, req_accept, resp_valid;
  logic [N*64-1:0]  req_addr, req_data;
  logic [N*SRC_W-1:0] req_source;
  logic [63:0]      resp_data, mem_req_addr, mem_req_data, mem_resp_data;
  logic             mem_req_valid, mem_req_write, mem_req_ready, mem_resp_valid, error;
  logic [SRC_W-1:0] mem_req_source, mem_resp_source;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  memory_bus_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_data(req_data), .req_source(req_source), .req_accept(req_accept),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_source(mem_req_source), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .mem_resp_source(mem_resp_source), .error(error)
  );

  task automatic clear_inputs;
    req_valid = '0; req_write = '0; req_addr = '0; req_data = '0; req_source = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_source = '0;
  endtask

  task automatic set_req(input int i, input logic w, input logic [63:0] a,
                         input logic [63:0] d, input logic [SRC_W-1:0] s);
    req_write[i] = w;
    req_addr[i*64 +: 64] = a;
    req_data[i*64 +: 64] = d;
    req_source[i*SRC_W +: SRC_W] = s;
    req_valid[i] = 1'b1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Waits (bounded) for any accept pulse; returns with the grant still pending its posedge.
  task automatic wait_any(input int budget, output logic [N-1:0] acc, output int cycles);
    acc = '0;
    cycles = 0;
    while (acc == '0 && cycles < budget) begin
      @(negedge clk); #1;
      cycles++;
      acc = req_accept;
    end
  endtask

  // Drives one memory response cycle; returns when its resp_valid should be visible.
  task automatic send_resp(input logic [63:0] d, input logic [SRC_W-1:0] s);
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_resp_data = d; mem_resp_source = s;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    clear_inputs();
    req_valid = '1; mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req_valid: got %b want 0", mem_req_valid); end
    vectors++; if (req_accept !== '0) begin miscompares++; $display("FAIL reset_req_accept: got %b want 0000", req_accept); end
    vectors++; if (resp_valid !== '0) begin miscompares++; $display("FAIL reset_resp_valid: got %b want 0000", resp_valid); end
    vectors++; if (mem_req_addr !== '0 || mem_req_source !== '0) begin miscompares++; $display("FAIL reset_payload: got %h/%h want 0", mem_req_addr, mem_req_source); end
    vectors++; if (error !== 1'b0 || resp_data !== '0) begin miscompares++; $display("FAIL reset_error_data: got %b/%h want 0", error, resp_data); end
    clear_inputs();
    reset = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_single_read;
    logic [N-1:0] acc; int cyc;
    do_reset();
    mem_req_ready = 1'b1;
    set_req(0, 1'b0, 64'h100, 64'h0, 8'h12);
    wait_any(4, acc, cyc);
    vectors++; if (acc !== 4'b0001 || cyc != 1) begin miscompares++; $display("FAIL single_accept: got %b after %0d want 0001 after 1", acc, cyc); end
    vectors++; if (mem_req_addr !== 64'h100 || mem_req_write !== 1'b0) begin miscompares++; $display("FAIL single_payload: got %h/%b want 100/0", mem_req_addr, mem_req_write); end
    @(negedge clk); req_valid = '0;
    repeat (2) @(negedge clk);
    mem_resp_valid = 1'b1; mem_resp_data = 64'hDEAD; mem_resp_source = 8'h12;
    #1;
    vectors++; if (resp_valid !== '0) begin miscompares++; $display("FAIL single_resp_early: got %b want 0000", resp_valid); end
    @(negedge clk); mem_resp_valid = 1'b0; #1;
    vectors++; if (resp_valid !== 4'b0001 || resp_data !== 64'hDEAD) begin miscompares++; $display("FAIL single_resp: got %b/%h want 0001/dead", resp_valid, resp_data); end
    @(negedge clk); #1;
    vectors++; if (resp_valid !== '0 || error !== 1'b0) begin miscompares++; $display("FAIL single_resp_pulse: got %b err %b want 0000 err 0", resp_valid, error); end
    $display("test_single_read done");
  endtask

  task automatic test_round_robin;
    logic [N-1:0] acc, exp_acc; int cyc;
    do_reset();
    mem_req_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 64'(i * 8), 64'(i), 8'(i));
    for (int k = 0; k < 5; k++) begin
      wait_any(6, acc, cyc);
      exp_acc = '0; exp_acc[k % N] = 1'b1;
      vectors++; if (acc !== exp_acc) begin miscompares++; $display("FAIL rr_order[%0d]: got %b want %b", k, acc, exp_acc); end
      vectors++; if (cyc != ((k == 0) ? 1 : 2)) begin miscompares++; $display("FAIL rr_spacing[%0d]: got %0d want %0d", k, cyc, (k == 0) ? 1 : 2); end
    end
    @(negedge clk); clear_inputs();
    $display("test_round_robin done");
  endtask

  task automatic test_stall;
    do_reset();
    set_req(2, 1'b0, 64'hABC0, 64'h0, 8'h2A);
    @(negedge clk); #1;
    set_req(0, 1'b1, 64'h1, 64'h1, 8'h01);
    set_req(1, 1'b1, 64'h2, 64'h2, 8'h02);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      vectors++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'hABC0 || mem_req_source !== 8'h2A || req_accept !== '0) begin
        miscompares++; $display("FAIL stall_hold[%0d]: got v%b %h %h acc %b want v1 abc0 2a acc 0000", k, mem_req_valid, mem_req_addr, mem_req_source, req_accept);
      end
    end
    mem_req_ready = 1'b1; #1;
    vectors++; if (req_accept !== 4'b0100) begin miscompares++; $display("FAIL stall_accept: got %b want 0100", req_accept); end
    @(negedge clk); clear_inputs(); #1;
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL stall_error: got %b want 0", error); end
    $display("test_stall done");
  endtask

  task automatic test_fifo_full;
    logic [N-1:0] acc; int cyc;
    do_reset();
    mem_req_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b0, 64'(k * 16), 64'h0, 8'(8'h40 + k));
      wait_any(4, acc, cyc);
      vectors++; if (acc !== 4'b0001) begin miscompares++; $display("FAIL full_fill[%0d]: got %b want 0001", k, acc); end
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    set_req(1, 1'b0, 64'h500, 64'h0, 8'h50);
    set_req(2, 1'b1, 64'h600, 64'hAA, 8'h60);
    wait_any(6, acc, cyc);
    vectors++; if (acc !== 4'b0100) begin miscompares++; $display("FAIL full_write_passes: got %b want 0100", acc); end
    @(negedge clk); req_valid[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL full_read_withheld[%0d]: got %b want 0", k, mem_req_valid); end
    end
    send_resp(64'h1111, 8'h40);
    vectors++; if (resp_valid !== 4'b0001 || resp_data !== 64'h1111) begin miscompares++; $display("FAIL full_resp: got %b/%h want 0001/1111", resp_valid, resp_data); end
    wait_any(4, acc, cyc);
    vectors++; if (acc !== 4'b0010) begin miscompares++; $display("FAIL full_read_freed: got %b want 0010", acc); end
    @(negedge clk); clear_inputs();
    $display("test_fifo_full done");
  endtask

  task automatic test_errors;
    logic [N-1:0] acc; int cyc;
    do_reset();
    mem_req_ready = 1'b1;
    set_req(0, 1'b0, 64'h200, 64'h0, 8'h21);
    wait_any(4, acc, cyc);
    @(negedge clk); clear_inputs();
    send_resp(64'hBEEF, 8'h22);
    vectors++; if (resp_valid !== 4'b0001 || resp_data !== 64'hBEEF) begin miscompares++; $display("FAIL mismatch_delivered: got %b/%h want 0001/beef", resp_valid, resp_data); end
    vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL mismatch_error: got %b want 1", error); end
    repeat (3) @(negedge clk); #1;
    vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL error_sticky: got %b want 1", error); end
    do_reset(); #1;
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL error_cleared: got %b want 0", error); end
    send_resp(64'hCAFE, 8'h21);
    vectors++; if (resp_valid !== '0 || error !== 1'b1) begin miscompares++; $display("FAIL empty_resp: got %b err %b want 0000 err 1", resp_valid, error); end
    $display("test_errors done");
  endtask

  task automatic test_drop;
    do_reset();
    set_req(3, 1'b1, 64'h300, 64'h33, 8'h30);
    @(negedge clk); #1;
    vectors++; if (mem_req_valid !== 1'b1 || error !== 1'b0) begin miscompares++; $display("FAIL drop_pre: got v%b err %b want v1 err 0", mem_req_valid, error); end
    req_valid[3] = 1'b0;
    @(negedge clk); #1;
    vectors++; if (error !== 1'b1 || mem_req_valid !== 1'b1) begin miscompares++; $display("FAIL drop_error: got err %b v%b want err 1 v1", error, mem_req_valid); end
    mem_req_ready = 1'b1; #1;
    vectors++; if (req_accept !== 4'b1000) begin miscompares++; $display("FAIL drop_completes: got %b want 1000", req_accept); end
    @(negedge clk); clear_inputs();
    $display("test_drop done");
  endtask

  task automatic test_reset_midflight;
    logic [N-1:0] acc; int cyc;
    do_reset();
    mem_req_ready = 1'b1;
    set_req(0, 1'b0, 64'h10, 64'h0, 8'h01);
    set_req(1, 1'b0, 64'h20, 64'h0, 8'h02);
    wait_any(4, acc, cyc);
    @(negedge clk); req_valid[0] = 1'b0;
    wait_any(4, acc, cyc);
    vectors++; if (acc !== 4'b0010) begin miscompares++; $display("FAIL midflight_second: got %b want 0010", acc); end
    @(negedge clk); req_valid[1] = 1'b0;
    set_req(2, 1'b0, 64'h30, 64'h0, 8'h03);
    mem_req_ready = 1'b0;
    @(negedge clk); #1;
    reset = 1'b0; clear_inputs();
    @(negedge clk); #1;
    vectors++; if (mem_req_valid !== 1'b0 || req_accept !== '0 || resp_valid !== '0 || mem_req_addr !== '0 || error !== 1'b0) begin
      miscompares++; $display("FAIL midflight_reset: got v%b acc %b rv %b addr %h err %b want all 0", mem_req_valid, req_accept, resp_valid, mem_req_addr, error);
    end
    reset = 1'b1;
    set_req(3, 1'b0, 64'h40, 64'h0, 8'h04);
    mem_req_ready = 1'b1;
    wait_any(4, acc, cyc);
    vectors++; if (acc !== 4'b1000) begin miscompares++; $display("FAIL midflight_new_accept: got %b want 1000", acc); end
    @(negedge clk); clear_inputs();
    send_resp(64'h4444, 8'h04);
    vectors++; if (resp_valid !== 4'b1000 || resp_data !== 64'h4444 || error !== 1'b0) begin
      miscompares++; $display("FAIL midflight_new_resp: got %b/%h err %b want 1000/4444 err 0", resp_valid, resp_data, error);
    end
    send_resp(64'h5555, 8'h01);
    vectors++; if (error !== 1'b1 || resp_valid !== '0) begin miscompares++; $display("FAIL midflight_late: got err %b rv %b want err 1 rv 0000", error, resp_valid); end
    $display("test_reset_midflight done");
  endtask

  // Randomized traffic against a transaction-level model: pending requests,
  // one grant in flight, round-robin choice, and an in-order read tag queue.
  task automatic test_random;
    bit               pend [N];
    logic             mw [N];
    logic [63:0]      ma [N];
    logic [63:0]      md [N];
    logic [SRC_W-1:0] ms [N];
    int               q_idx [$];
    logic [SRC_W-1:0] q_src [$];
    int cur, last, win, j, sz;
    logic [N-1:0] exp_rv, next_rv, exp_acc;
    logic [63:0]  exp_rd;
    do_reset();
    cur = -1; last = N - 1; exp_rv = '0; exp_rd = '0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          mw[i] = 1'($urandom_range(0, 1));
          ma[i] = {$urandom, $urandom};
          md[i] = {$urandom, $urandom};
          ms[i] = SRC_W'($urandom);
          set_req(i, mw[i], ma[i], md[i], ms[i]);
        end
        req_valid[i] = pend[i];
      end
      mem_req_ready = ($urandom_range(0, 3) != 0);
      if (q_idx.size() != 0 && $urandom_range(0, 2) == 0) begin
        mem_resp_valid = 1'b1; mem_resp_data = {$urandom, $urandom}; mem_resp_source = q_src[0];
      end else begin
        mem_resp_valid = 1'b0;
      end
      #1;
      exp_acc = '0;
      if (cur >= 0 && mem_req_ready) exp_acc[cur] = 1'b1;
      vectors++; if (mem_req_valid !== (cur >= 0)) begin miscompares++; $display("FAIL rand_mem_valid c%0d: got %b want %b", c, mem_req_valid, cur >= 0); end
      if (cur >= 0) begin
        vectors++; if (mem_req_addr !== ma[cur] || mem_req_data !== md[cur] || mem_req_write !== mw[cur] || mem_req_source !== ms[cur]) begin
          miscompares++; $display("FAIL rand_payload c%0d: got %h %h %b %h want %h %h %b %h", c, mem_req_addr, mem_req_data, mem_req_write, mem_req_source, ma[cur], md[cur], mw[cur], ms[cur]);
        end
      end
      vectors++; if (req_accept !== exp_acc) begin miscompares++; $display("FAIL rand_accept c%0d: got %b want %b", c, req_accept, exp_acc); end
      vectors++; if (resp_valid !== exp_rv) begin miscompares++; $display("FAIL rand_resp_valid c%0d: got %b want %b", c, resp_valid, exp_rv); end
      if (exp_rv != '0) begin
        vectors++; if (resp_data !== exp_rd) begin miscompares++; $display("FAIL rand_resp_data c%0d: got %h want %h", c, resp_data, exp_rd); end
      end
      vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL rand_error c%0d: got %b want 0", c, error); end
      // Reference update for the coming clock edge.
      sz = q_idx.size();
      if (cur < 0) begin
        win = -1;
        for (int k = 1; k <= N; k++) begin
          j = (last + k) % N;
          if (win < 0 && pend[j] && (mw[j] || sz < 4)) win = j;
        end
        cur = win;
      end else if (mem_req_ready) begin
        pend[cur] = 1'b0;
        last = cur;
        if (!mw[cur]) begin q_idx.push_back(cur); q_src.push_back(ms[cur]); end
        cur = -1;
      end
      next_rv = '0;
      if (mem_resp_valid) begin
        next_rv[q_idx[0]] = 1'b1;
        exp_rd = mem_resp_data;
        void'(q_idx.pop_front());
        void'(q_src.pop_front());
      end
      exp_rv = next_rv;
    end
    $display("test_random done");
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_stall();
    test_fifo_full();
    test_errors();
    test_drop();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
